// File: rtl/cacc_asm_pkg.sv
// Shared types and constants for the CACC assembly controller.
// Tag bit positions and packet layout live here so the top and bench agree.
package cacc_asm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } asm_state_t;

    localparam int TAG_W           = 9;
    localparam int TAG_STRIPE_ST   = 5;
    localparam int TAG_STRIPE_END  = 6;
    localparam int TAG_CHANNEL_END = 7;
    localparam int TAG_LAYER_END   = 8;

    localparam logic [2:0] PD_RSVD = 3'b001;

    localparam logic [1:0] PREC_INT8  = 2'd0;
    localparam logic [1:0] PREC_INT16 = 2'd1;
    localparam logic [1:0] PREC_FP16  = 2'd2;

    localparam int SLCG_DLY = 3;

    function automatic int ctrl_pd_w(input int aw);
        return aw + 7;
    endfunction

    // int8 packs two elements per lane, wider formats use only the low one
    function automatic logic [1:0] in_en_mask(input logic [1:0] prec);
        case (prec)
            PREC_INT8:             return 2'b11;
            PREC_INT16, PREC_FP16: return 2'b01;
            default:               return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/cacc_assembly_ctrl_gen_if.sv
// MAC tag input and ABUF/accumulator control output bundle.
// The slave side is the assembly controller; the master side feeds MAC tags.
interface cacc_assembly_ctrl_gen_if #(
    parameter int ABUF_AW = 6,
    parameter int NUM_MAC = 2
);
    localparam int CTRL_PD_W = cacc_asm_pkg::ctrl_pd_w(ABUF_AW);

    logic [NUM_MAC-1:0]                  mac_pvld;
    logic [cacc_asm_pkg::TAG_W-1:0]      mac_pd;
    logic                                abuf_rd_en;
    logic [ABUF_AW-1:0]                  abuf_rd_addr;
    logic                                accu_ctrl_valid;
    logic                                accu_ctrl_ram_valid;
    logic [CTRL_PD_W-1:0]                accu_ctrl_pd;

    modport master (
        output mac_pvld, mac_pd,
        input  abuf_rd_en, abuf_rd_addr, accu_ctrl_valid, accu_ctrl_ram_valid, accu_ctrl_pd
    );

    modport slave (
        input  mac_pvld, mac_pd,
        output abuf_rd_en, abuf_rd_addr, accu_ctrl_valid, accu_ctrl_ram_valid, accu_ctrl_pd
    );
endinterface

// File: rtl/cacc_asm_delay_line.sv
// Fixed-depth valid/data shift line; data stages only load behind a set valid.
// Used for ABUF read-latency alignment and for the clock-gate enable delay.
module cacc_asm_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            vld_q[0] <= vld_in;
            if (vld_in) data_q[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_out  = vld_q[DEPTH-1];
    assign data_out = data_q[DEPTH-1];
endmodule

// File: rtl/cacc_assembly_ctrl_gen.sv
// CACC assembly controller: registers MAC tags, drives ABUF reads and emits
// the accumulator control packet aligned to the ABUF read latency.
//
//   state    | meaning
//   ST_IDLE  | waiting for reg2dp_op_en; tags are ignored and flagged
//   ST_RUN   | layer active; tags advance the address counter and emit packets
//   ST_DRAIN | layer_end seen; waiting for dp2reg_done, tags silently dropped
module cacc_assembly_ctrl_gen
    import cacc_asm_pkg::*;
#(
    parameter int ABUF_AW     = 6,
    parameter int NUM_MAC     = 2,
    parameter int ABUF_RD_LAT = 1,
    parameter int TRUNC_W     = 5
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 reg2dp_op_en,
    input  logic                 reg2dp_conv_mode,
    input  logic [1:0]           reg2dp_proc_precision,
    input  logic [TRUNC_W-1:0]   reg2dp_clip_truncate,
    input  logic                 dp2reg_done,
    cacc_assembly_ctrl_gen_if.slave bus,
    output logic                 cfg_is_wg,
    output logic [TRUNC_W-1:0]   cfg_truncate,
    output logic [1:0]           cfg_in_en_mask,
    output logic                 wait_for_op_en,
    output logic                 slcg_cell_en,
    output logic                 err_pvld_mismatch,
    output logic                 err_addr_ovf,
    output logic                 err_unexp_vld
);
    localparam int CTRL_PD_W = ctrl_pd_w(ABUF_AW);
    localparam logic [ABUF_AW-1:0] CNT_MAX = '1;

    asm_state_t state, state_nxt;

    logic                 in_vld;
    logic                 in_stripe_end, in_channel_end, in_layer_end;
    logic [ABUF_AW-1:0]   accu_cnt;
    logic                 channel_st;
    logic                 pvld_any, pvld_all, layer_st, run_vld;
    logic [CTRL_PD_W-1:0] pkt_pd;
    logic                 line_vld;
    logic [CTRL_PD_W:0]   line_data;
    logic                 slcg_vld, slcg_data;
    logic                 unused_pd;

    assign pvld_any  = |bus.mac_pvld;
    assign pvld_all  = &bus.mac_pvld;
    assign layer_st  = (state == ST_IDLE) & reg2dp_op_en;
    assign run_vld   = in_vld & (state == ST_RUN);
    assign unused_pd = ^bus.mac_pd[TAG_STRIPE_ST:0];

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    // abort on dp2reg_done wins over a layer_end arriving in the same cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (reg2dp_op_en) state_nxt = ST_RUN;
            ST_RUN: begin
                if (dp2reg_done)                 state_nxt = ST_IDLE;
                else if (in_vld && in_layer_end) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (dp2reg_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            in_vld            <= 1'b0;
            in_stripe_end     <= 1'b0;
            in_channel_end    <= 1'b0;
            in_layer_end      <= 1'b0;
            accu_cnt          <= '0;
            channel_st        <= 1'b1;
            cfg_is_wg         <= 1'b0;
            cfg_truncate      <= '0;
            cfg_in_en_mask    <= 2'b00;
            wait_for_op_en    <= 1'b1;
            err_pvld_mismatch <= 1'b0;
            err_addr_ovf      <= 1'b0;
            err_unexp_vld     <= 1'b0;
        end else begin
            in_vld         <= pvld_any;
            wait_for_op_en <= (state_nxt == ST_IDLE);
            if (pvld_any) begin
                in_stripe_end  <= bus.mac_pd[TAG_STRIPE_END];
                in_channel_end <= bus.mac_pd[TAG_CHANNEL_END];
                in_layer_end   <= bus.mac_pd[TAG_LAYER_END];
            end
            if (pvld_any && !pvld_all)        err_pvld_mismatch <= 1'b1;
            if (in_vld && state == ST_IDLE)   err_unexp_vld     <= 1'b1;
            // stripe_end restart takes precedence over saturation
            if (run_vld) begin
                if (in_stripe_end) begin
                    accu_cnt   <= '0;
                    channel_st <= in_channel_end;
                end else if (accu_cnt == CNT_MAX) begin
                    err_addr_ovf <= 1'b1;
                end else begin
                    accu_cnt <= accu_cnt + ABUF_AW'(1);
                end
            end
            if (layer_st) begin
                cfg_is_wg         <= reg2dp_conv_mode;
                cfg_truncate      <= reg2dp_clip_truncate;
                cfg_in_en_mask    <= in_en_mask(reg2dp_proc_precision);
                err_pvld_mismatch <= 1'b0;
                err_addr_ovf      <= 1'b0;
                err_unexp_vld     <= 1'b0;
                accu_cnt          <= '0;
                channel_st        <= 1'b1;
            end
        end
    end

    assign bus.abuf_rd_en   = run_vld & ~channel_st;
    assign bus.abuf_rd_addr = accu_cnt;
    assign pkt_pd = {in_channel_end, in_layer_end, in_channel_end, in_stripe_end, PD_RSVD, accu_cnt};

    cacc_asm_delay_line #(.WIDTH(CTRL_PD_W + 1), .DEPTH(ABUF_RD_LAT)) u_align (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .vld_in   (run_vld),
        .data_in  ({bus.abuf_rd_en, pkt_pd}),
        .vld_out  (line_vld),
        .data_out (line_data)
    );

    assign bus.accu_ctrl_valid     = line_vld;
    assign bus.accu_ctrl_ram_valid = line_vld & line_data[CTRL_PD_W];
    assign bus.accu_ctrl_pd        = line_data[CTRL_PD_W-1:0];

    cacc_asm_delay_line #(.WIDTH(1), .DEPTH(SLCG_DLY)) u_slcg (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .vld_in   (reg2dp_op_en),
        .data_in  (reg2dp_op_en),
        .vld_out  (slcg_vld),
        .data_out (slcg_data)
    );

    assign slcg_cell_en = slcg_vld & slcg_data;
endmodule

// File: tb/tb_cacc_assembly_ctrl_gen.sv
// Directed bench for the CACC assembly controller: two instances (wide/short-latency
// and narrow/long-latency) share one stimulus stream.
module tb_cacc_assembly_ctrl_gen;
    localparam int NUM_MAC = 2;
    localparam int TRUNC_W = 5;
    localparam int AW_A = 6, LAT_A = 1;
    localparam int AW_B = 3, LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_en = 1'b0, conv_mode = 1'b0, done = 1'b0;
    logic [1:0] prec = 2'd0;
    logic [TRUNC_W-1:0] trunc = '0;
    logic [NUM_MAC-1:0] pvld = '0;
    logic [8:0] mac_pd = '0;

    logic cfg_is_wg_a, wait_a, slcg_a, err_pvld_a, err_ovf_a, err_unexp_a;
    logic cfg_is_wg_b, wait_b, slcg_b, err_pvld_b, err_ovf_b, err_unexp_b;
    logic [TRUNC_W-1:0] cfg_trunc_a, cfg_trunc_b;
    logic [1:0] cfg_mask_a, cfg_mask_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cacc_assembly_ctrl_gen_if #(.ABUF_AW(AW_A), .NUM_MAC(NUM_MAC)) bus_a ();
    cacc_assembly_ctrl_gen_if #(.ABUF_AW(AW_B), .NUM_MAC(NUM_MAC)) bus_b ();

    assign bus_a.mac_pvld = pvld;
    assign bus_a.mac_pd   = mac_pd;
    assign bus_b.mac_pvld = pvld;
    assign bus_b.mac_pd   = mac_pd;

    cacc_assembly_ctrl_gen #(.ABUF_AW(AW_A), .NUM_MAC(NUM_MAC), .ABUF_RD_LAT(LAT_A), .TRUNC_W(TRUNC_W)) dut_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en), .reg2dp_conv_mode(conv_mode),
        .reg2dp_proc_precision(prec), .reg2dp_clip_truncate(trunc), .dp2reg_done(done), .bus(bus_a),
        .cfg_is_wg(cfg_is_wg_a), .cfg_truncate(cfg_trunc_a), .cfg_in_en_mask(cfg_mask_a),
        .wait_for_op_en(wait_a), .slcg_cell_en(slcg_a), .err_pvld_mismatch(err_pvld_a),
        .err_addr_ovf(err_ovf_a), .err_unexp_vld(err_unexp_a)
    );

    cacc_assembly_ctrl_gen #(.ABUF_AW(AW_B), .NUM_MAC(NUM_MAC), .ABUF_RD_LAT(LAT_B), .TRUNC_W(TRUNC_W)) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en), .reg2dp_conv_mode(conv_mode),
        .reg2dp_proc_precision(prec), .reg2dp_clip_truncate(trunc), .dp2reg_done(done), .bus(bus_b),
        .cfg_is_wg(cfg_is_wg_b), .cfg_truncate(cfg_trunc_b), .cfg_in_en_mask(cfg_mask_b),
        .wait_for_op_en(wait_b), .slcg_cell_en(slcg_b), .err_pvld_mismatch(err_pvld_b),
        .err_addr_ovf(err_ovf_b), .err_unexp_vld(err_unexp_b)
    );

    // tag = {layer_end, channel_end, stripe_end}; err = {pvld_mismatch, addr_ovf, unexp_vld}
    typedef struct packed {
        logic        op_en;
        logic        done;
        logic [1:0]  pvld;
        logic [2:0]  tag;
        logic        wait_e;
        logic        rd_en;
        logic [5:0]  addr;
        logic        valid;
        logic        ram;
        logic [12:0] pd;
        logic [2:0]  err;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic op, input logic dn, input logic [1:0] pv, input logic [2:0] tag);
        op_en  = op;
        done   = dn;
        pvld   = pv;
        mac_pd = {tag, 6'b010101};
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [25:0] obs_a();
        return {wait_a, bus_a.abuf_rd_en, bus_a.abuf_rd_addr, bus_a.accu_ctrl_valid,
                bus_a.accu_ctrl_ram_valid, bus_a.accu_ctrl_pd, err_pvld_a, err_ovf_a, err_unexp_a};
    endfunction

    initial begin
        int n;
        //          op    dn    pvld   tag     wait  rd    addr   v     ram   pd        err
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 13'h000, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 13'h000, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 13'h040, 3'b000};
        vecs[3]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 13'h041, 3'b000};
        vecs[4]  = '{1'b1, 1'b0, 2'b11, 3'b001, 1'b0, 1'b0, 6'd3, 1'b1, 1'b0, 13'h042, 3'b000};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 13'h243, 3'b000};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 13'h243, 3'b000};
        vecs[7]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 13'h243, 3'b000};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b1, 6'd1, 1'b1, 1'b1, 13'h040, 3'b000};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b1, 6'd2, 1'b1, 1'b1, 13'h041, 3'b000};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 3'b011, 1'b0, 1'b1, 6'd3, 1'b1, 1'b1, 13'h042, 3'b000};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 13'h1643, 3'b000};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 13'h1643, 3'b000};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 3'b100, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 13'h1643, 3'b000};
        vecs[14] = '{1'b1, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 13'h840, 3'b000};
        vecs[15] = '{1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, 13'h840, 3'b000};
        vecs[16] = '{1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 13'h840, 3'b000};
        vecs[17] = '{1'b0, 1'b0, 2'b11, 3'b000, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 13'h840, 3'b000};
        vecs[18] = '{1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 13'h840, 3'b001};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_a", 64'(obs_a()), 64'({1'b1, 25'b0}));
        check("rst_b", 64'({wait_b, bus_b.abuf_rd_en, bus_b.abuf_rd_addr, bus_b.accu_ctrl_valid,
                            bus_b.accu_ctrl_ram_valid, bus_b.accu_ctrl_pd, err_pvld_b, err_ovf_b, err_unexp_b}),
              64'({1'b1, 19'b0}));
        check("rst_cfg", 64'({cfg_is_wg_a, cfg_trunc_a, cfg_mask_a, slcg_a}), 64'(0));
        rst = 1'b0;

        // Layer 1: first stripe without reads, second stripe with reads, then drain/idle
        prec = 2'd1; conv_mode = 1'b0; trunc = 5'd9;
        for (int i = 0; i < 19; i++) begin
            if (i == 1) begin
                trunc = 5'd3; prec = 2'd0; conv_mode = 1'b1;
            end
            step(vecs[i].op_en, vecs[i].done, vecs[i].pvld, vecs[i].tag);
            check($sformatf("vec%0d", i), 64'(obs_a()),
                  64'({vecs[i].wait_e, vecs[i].rd_en, vecs[i].addr, vecs[i].valid,
                       vecs[i].ram, vecs[i].pd, vecs[i].err}));
        end
        check("cfg_hold", 64'({cfg_is_wg_a, cfg_trunc_a, cfg_mask_a}), 64'({1'b0, 5'd9, 2'b01}));

        // Layer 2: winograd/int8 config, errors cleared, then address saturation on the 3-bit instance
        trunc = 5'd21; prec = 2'd0; conv_mode = 1'b1;
        step(1'b1, 1'b0, 2'b00, 3'b000);
        check("cfg_l2", 64'({cfg_is_wg_a, cfg_trunc_a, cfg_mask_a}), 64'({1'b1, 5'd21, 2'b11}));
        check("err_clr_l2", 64'({wait_a, err_pvld_a, err_ovf_a, err_unexp_a}), 64'(0));
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 2'b11, 3'b000);
            check($sformatf("ovf_k%0d", k), 64'({bus_b.abuf_rd_addr, err_ovf_b}),
                  64'({((k > 7) ? 3'd7 : 3'(k)), (k == 8)}));
        end
        step(1'b0, 1'b0, 2'b00, 3'b000);
        check("ovf_sticky_b", 64'(err_ovf_b), 64'(1));
        check("ovf_none_a", 64'({err_ovf_a, bus_a.abuf_rd_addr}), 64'({1'b0, 6'd9}));
        repeat (3) step(1'b0, 1'b0, 2'b00, 3'b000);

        // Read latency of 3: open a read stripe, flush, then a single isolated read
        step(1'b0, 1'b0, 2'b11, 3'b001);
        repeat (4) step(1'b0, 1'b0, 2'b00, 3'b000);
        step(1'b0, 1'b0, 2'b11, 3'b000);
        check("lat_rd", 64'({bus_b.abuf_rd_en, bus_b.abuf_rd_addr, bus_b.accu_ctrl_valid}),
              64'({1'b1, 3'd0, 1'b0}));
        n = 0;
        while (!bus_b.accu_ctrl_valid && n < 8) begin
            step(1'b0, 1'b0, 2'b00, 3'b000);
            n++;
        end
        check("lat_cycles", 64'(n), 64'(3));
        check("lat_pd", 64'({bus_b.accu_ctrl_ram_valid, bus_b.accu_ctrl_pd}), 64'({1'b1, 10'h008}));

        // Partial valid across MAC cells
        step(1'b0, 1'b0, 2'b01, 3'b000);
        check("pvld_mismatch", 64'(err_pvld_a), 64'(1));
        step(1'b0, 1'b1, 2'b00, 3'b000);
        check("done_idle", 64'(wait_a), 64'(1));
        repeat (3) step(1'b0, 1'b0, 2'b00, 3'b000);

        // Layer 3: fp16 config, clock-gate delay, then reset mid-stripe
        trunc = 5'd7; prec = 2'd2; conv_mode = 1'b0;
        step(1'b1, 1'b0, 2'b00, 3'b000);
        check("cfg_l3", 64'({cfg_is_wg_a, cfg_trunc_a, cfg_mask_a}), 64'({1'b0, 5'd7, 2'b01}));
        check("err_clr_l3", 64'({err_pvld_a, err_ovf_b, err_unexp_a, slcg_a}), 64'(0));
        step(1'b1, 1'b0, 2'b11, 3'b001);
        check("slcg_e2", 64'(slcg_a), 64'(0));
        step(1'b1, 1'b0, 2'b11, 3'b000);
        check("slcg_e3", 64'(slcg_a), 64'(1));
        check("pre_rst_rd", 64'({bus_a.abuf_rd_en, bus_a.abuf_rd_addr}), 64'({1'b1, 6'd0}));
        step(1'b1, 1'b0, 2'b11, 3'b000);
        check("pre_rst_vld", 64'(bus_a.accu_ctrl_valid), 64'(1));
        rst = 1'b1;
        step(1'b1, 1'b0, 2'b11, 3'b000);
        check("rst_mid", 64'({obs_a(), cfg_is_wg_a, cfg_trunc_a, cfg_mask_a, slcg_a}),
              64'({1'b1, 25'b0, 9'b0}));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cacc_assembly_ctrl_gen.md
Name: cacc_assembly_ctrl_gen

Overview:
Parametrised assembly controller for CACC. It registers MAC-cell partial-sum tags and generates the accumulation-buffer (ABUF) read address and read enable. It also emits the accumulator control packet, aligned to a configurable ABUF read latency. Compared with the fixed-width controller, it adds a layer FSM, real winograd/precision config latching, multi-cell valid checking, address-overflow saturation and sticky error flags.

Parameters:
ABUF_AW, 6, ABUF address width (1..8)
NUM_MAC, 2, number of MAC cells feeding the block (1..4)
ABUF_RD_LAT, 1, ABUF read latency in cycles, from abuf_rd_en to data (1..3)
TRUNC_W, 5, truncate field width
CTRL_PD_W, ABUF_AW+7, derived; not overridable

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  reset; one clock; reset is synchronous and active-high
reg2dp_op_en  in  1  layer enable
reg2dp_conv_mode  in  1  1 = winograd
reg2dp_proc_precision  in  2  0 = int8, 1 = int16, 2 = fp16
reg2dp_clip_truncate  in  TRUNC_W  truncate amount
dp2reg_done  in  1  layer done from CACC delivery
mac_pvld  in  NUM_MAC  per-cell valid
mac_pd  in  9  tag from cell 0: [5] stripe_st, [6] stripe_end, [7] channel_end, [8] layer_end; [4:0] unused
abuf_rd_en  out  1  ABUF read enable
abuf_rd_addr  out  ABUF_AW  ABUF read address
accu_ctrl_valid  out  1  control packet valid
accu_ctrl_ram_valid  out  1  ABUF data valid alongside packet
accu_ctrl_pd  out  CTRL_PD_W  packet: {dlv_elem_mask, layer_end, channel_end, stripe_end, 3'b001, addr}
cfg_is_wg  out  1  latched winograd
cfg_truncate  out  TRUNC_W  latched truncate
cfg_in_en_mask  out  2  int8 -> 2'b11, else 2'b01
wait_for_op_en  out  1  FSM in IDLE
slcg_cell_en  out  1  reg2dp_op_en delayed 3 cycles
err_pvld_mismatch  out  1  sticky: mac_pvld not all-equal
err_addr_ovf  out  1  sticky: address counter saturated
err_unexp_vld  out  1  sticky: input valid seen while IDLE

Behaviour:
- Reset values:
  - all outputs 0, except wait_for_op_en = 1
  - FSM = IDLE; accu_cnt = 0; channel_st = 1.
- Input stage:
  - in_vld <= |mac_pvld.
  - in_pd is loaded from mac_pd only when |mac_pvld.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when reg2dp_op_en. This is layer_st.
  - RUN -> DRAIN on an in_vld carrying layer_end.
  - DRAIN -> IDLE on dp2reg_done.
  - RUN -> IDLE on dp2reg_done (abort); this takes priority over a simultaneous layer_end.
  - wait_for_op_en = (state == IDLE), registered.
- layer_st actions:
  - latch cfg_is_wg, cfg_truncate and cfg_in_en_mask;
  - clear all three sticky errors;
  - set accu_cnt = 0 and channel_st = 1.
  - Config outputs do not change at any other time.
- Address counter (updates on in_vld in RUN):
  - stripe_end -> accu_cnt = 0.
  - accu_cnt == 2^ABUF_AW-1 without stripe_end -> hold value, set err_addr_ovf.
  - Otherwise increment by 1.
- channel_st:
  - On in_vld with stripe_end, channel_st <= channel_end.
  - abuf_rd_en = in_vld & ~channel_st & (state == RUN).
  - abuf_rd_addr = accu_cnt.
  - The first channel group of each stripe therefore performs no read.
- in_vld in IDLE or DRAIN:
  - Ignored: no counter update, no rd_en, no packet.
  - Sets err_unexp_vld; exception: a valid in DRAIN does not set it.
- Error check: err_pvld_mismatch is set when mac_pvld is neither all-0 nor all-1.
- Output pipeline:
  - A RUN in_vld at cycle T produces abuf_rd_en at T (rd_en itself derives from mac_pvld at T-1).
  - accu_ctrl_valid, ram_valid and pd appear at T+ABUF_RD_LAT.
  - Implementation is an ABUF_RD_LAT-deep shift line.
  - Valid bits reset to 0; pd stages load only when their valid is set.
  - ram_valid equals the delayed abuf_rd_en.
  - dlv_elem_mask equals channel_end.
- Simultaneous stripe_end with overflow: the reset to 0 wins and no error is raised.
- Reset mid-layer: everything returns to reset values at the next edge; in-flight packets are dropped.

Decomposition:
- Package cacc_asm_pkg holds:
  - the FSM state enum;
  - tag bit positions (5..8);
  - the reserved constant 3'b001;
  - precision encodings;
  - the CTRL_PD_W derivation.
- Sub-module cacc_asm_delay_line (parametrised width and depth, valid-gated load) is used for the output alignment and reused for the SLCG 3-cycle delay.

Test Plan:
1. ABUF_AW=6, RD_LAT=1. op_en, then 4 valids with the 4th carrying stripe_end+channel_end=0 -> rd_en=0 throughout; packets with addr 0,1,2,3; ram_valid=0; packet 4 pd[ABUF_AW+3]=1.
2. Second stripe after test 1, 4 valids -> rd_en=1 at addr 0..3; ram_valid=1 one cycle later; final packet with channel_end=1 sets dlv_elem_mask=1.
3. ABUF_AW=3. 9 valids with no stripe_end -> addr 0..7, then 7 again; err_addr_ovf=1; cleared at next layer_st.
4. RD_LAT=3 -> accu_ctrl_valid exactly 3 cycles after abuf_rd_en; pd addr matches.
5. layer_end valid -> DRAIN. A further valid is ignored with no error. dp2reg_done -> wait_for_op_en=1 next cycle. A valid in IDLE -> err_unexp_vld=1.
6. NUM_MAC=2, mac_pvld=2'b01 -> err_pvld_mismatch=1. Precision 0 -> cfg_in_en_mask=2'b11; precision 2 -> 2'b01. conv_mode=1 -> cfg_is_wg=1. Reset asserted mid-stripe -> all outputs 0 and wait_for_op_en=1 next cycle.
